// File: rtl/iitb_pkg.sv
// Shared IITB-RISC constants and types.
// Imported by the LM/SM sequencer and the hazard logic.
package iitb_pkg;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam int DATA_W = 16;
  localparam int LIST_W = 8;
  localparam int RA_W   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc_msb.sv
// Most-significant-set-bit priority encoder.
// Returns the bit position of the highest set bit plus an any-set flag.
module prio_enc_msb #(
  parameter int LIST_W = 8,
  parameter int RA_W   = 3
) (
  input  logic [LIST_W-1:0] list,
  output logic [RA_W-1:0]   idx,
  output logic              any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < LIST_W; i++) begin
      if (list[i]) begin
        idx = i[RA_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// IITB-RISC LM/SM sequencer: one register transfer per cycle,
// R0 first, contiguous addresses, fetch stalled until the last one.
module lm_sm_sequencer #(
  parameter int DATA_W = 16,
  parameter int LIST_W = 8,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_lm,
  input  logic [LIST_W-1:0] reg_list,
  input  logic [DATA_W-1:0] base_addr,
  input  logic              hold,
  input  logic              flush,
  output logic              busy,
  output logic              stall_fetch,
  output logic              xfer_valid,
  output logic [RA_W-1:0]   xfer_reg,
  output logic [DATA_W-1:0] xfer_addr,
  output logic              xfer_ld,
  output logic              xfer_st,
  output logic              xfer_last
);

  import iitb_pkg::*;

  state_t              state;
  logic [LIST_W-1:0]   list_q;
  logic [DATA_W-1:0]   addr_q;
  logic                lm_q;

  logic [RA_W-1:0]     bitpos;
  logic                any;
  logic [LIST_W-1:0]   onehot;
  logic                one_left;
  logic                accept;
  logic                issue;

  prio_enc_msb #(
    .LIST_W(LIST_W),
    .RA_W  (RA_W)
  ) u_enc (
    .list(list_q),
    .idx (bitpos),
    .any (any)
  );

  assign onehot   = LIST_W'(1) << bitpos;
  // x & (x-1) clears the lowest set bit; zero means a single bit left
  assign one_left = any &
    ((list_q & (list_q - LIST_W'(1))) == '0);

  assign accept = (state == ST_IDLE) & start &
                  ~flush & (|reg_list);
  assign issue  = (state == ST_RUN) & any &
                  ~hold & ~flush & ~rst;

  assign busy        = (state == ST_RUN);
  assign stall_fetch = accept |
    ((state == ST_RUN) & ~flush & ~(issue & one_left));
  assign xfer_valid  = issue;
  assign xfer_reg    = issue ?
    (RA_W'(LIST_W - 1) - bitpos) : '0;
  assign xfer_addr   = issue ? addr_q : '0;
  assign xfer_ld     = issue & lm_q;
  assign xfer_st     = issue & ~lm_q;
  assign xfer_last   = issue & one_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      list_q <= '0;
      addr_q <= '0;
      lm_q   <= 1'b0;
    end else if (flush) begin
      state  <= ST_IDLE;
      list_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_RUN;
            list_q <= reg_list;
            addr_q <= base_addr;
            lm_q   <= is_lm;
          end
        end
        ST_RUN: begin
          if (!any) begin
            state <= ST_IDLE;
          end else if (!hold) begin
            list_q <= list_q & ~onehot;
            addr_q <= addr_q + DATA_W'(1);
            if (one_left) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer.
// Expected transfers are queued at stimulus time and popped on issue.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, is_lm, hold, flush;
  logic [7:0]  reg_list;
  logic [15:0] base_addr;
  logic        busy, stall_fetch, xfer_valid;
  logic [2:0]  xfer_reg;
  logic [15:0] xfer_addr;
  logic        xfer_ld, xfer_st, xfer_last;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] a;
    logic        ld;
    logic        last;
  } exp_t;

  exp_t sb[$];

  lm_sm_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_lm      (is_lm),
    .reg_list   (reg_list),
    .base_addr  (base_addr),
    .hold       (hold),
    .flush      (flush),
    .busy       (busy),
    .stall_fetch(stall_fetch),
    .xfer_valid (xfer_valid),
    .xfer_reg   (xfer_reg),
    .xfer_addr  (xfer_addr),
    .xfer_ld    (xfer_ld),
    .xfer_st    (xfer_st),
    .xfer_last  (xfer_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: R0 first (bit 7), addresses contiguous
  task automatic push_model(input logic [7:0] l,
                            input logic [15:0] b,
                            input logic ld);
    int n;
    int k;
    exp_t e;
    n = $countones(l);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (l[7-i]) begin
        e.r    = 3'(i);
        e.a    = b + 16'(k);
        e.ld   = ld;
        e.last = (k == n - 1);
        sb.push_back(e);
        k++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (xfer_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_xfer reg=%0d addr=%h",
                 xfer_reg, xfer_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (xfer_reg !== e.r || xfer_addr !== e.a ||
            xfer_ld !== e.ld || xfer_st !== !e.ld ||
            xfer_last !== e.last) begin
          bad++;
          $display("FAIL xfer got r=%0d a=%h ld=%b st=%b last=%b want r=%0d a=%h ld=%b st=%b last=%b",
                   xfer_reg, xfer_addr, xfer_ld, xfer_st,
                   xfer_last, e.r, e.a, e.ld, !e.ld, e.last);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; is_lm = 0; hold = 0; flush = 0;
    reg_list = 0; base_addr = 0;
    step(); step();
    rst = 0;
    @(negedge clk);
    total++;
    if ({busy, stall_fetch, xfer_valid, xfer_reg, xfer_addr,
         xfer_ld, xfer_st, xfer_last} !== '0) begin
      bad++;
      $display("FAIL reset_outputs busy=%b stall=%b valid=%b",
               busy, stall_fetch, xfer_valid);
    end
    step();
  endtask

  task automatic run_seq(input string name, input logic lm,
                         input logic [7:0] l,
                         input logic [15:0] b);
    int n;
    n = $countones(l);
    push_model(l, b, lm);
    start = 1; is_lm = lm; reg_list = l; base_addr = b;
    @(negedge clk);
    chk({name, "_accept_stall"}, 32'(stall_fetch), 32'd1);
    step();
    start = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk({name, "_stall"}, 32'(stall_fetch), 32'(k != n));
      chk({name, "_busy"}, 32'(busy), 32'd1);
      step();
    end
    @(negedge clk);
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_drain"}, 32'(sb.size()), 32'd0);
    step();
  endtask

  task automatic test_lm_basic();
    run_seq("lm_basic", 1'b1, 8'b1010_0001, 16'h0040);
  endtask

  task automatic test_sm_wrap();
    run_seq("sm_wrap", 1'b0, 8'hFF, 16'hFFFE);
  endtask

  task automatic test_zero_list();
    start = 1; is_lm = 1; reg_list = 8'h00; base_addr = 16'h0033;
    @(negedge clk);
    chk("zero_stall", 32'(stall_fetch), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_valid", 32'(xfer_valid), 32'd0);
    step();
    start = 0;
    run_seq("after_zero", 1'b1, 8'h01, 16'h0005);
  endtask

  task automatic test_hold();
    push_model(8'b1100_0000, 16'h0010, 1'b1);
    start = 1; is_lm = 1; reg_list = 8'b1100_0000;
    base_addr = 16'h0010;
    step();
    start = 0;
    @(negedge clk);
    chk("hold_first_valid", 32'(xfer_valid), 32'd1);
    step();
    hold = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(xfer_valid), 32'd0);
      chk("hold_stall", 32'(stall_fetch), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      step();
    end
    hold = 0;
    @(negedge clk);
    chk("hold_last_valid", 32'(xfer_valid), 32'd1);
    chk("hold_last_stall", 32'(stall_fetch), 32'd0);
    step();
    @(negedge clk);
    chk("hold_idle", 32'(busy), 32'd0);
    chk("hold_drain", 32'(sb.size()), 32'd0);
    step();
  endtask

  task automatic test_flush();
    exp_t e;
    e.r = 3'd4; e.a = 16'h0200; e.ld = 1'b0; e.last = 1'b0;
    sb.push_back(e);
    start = 1; is_lm = 0; reg_list = 8'h0F; base_addr = 16'h0200;
    step();
    start = 0;
    step();
    flush = 1;
    @(negedge clk);
    chk("flush_valid", 32'(xfer_valid), 32'd0);
    step();
    flush = 0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_stall", 32'(stall_fetch), 32'd0);
    chk("flush_list", 32'(dut.list_q), 32'd0);
    step();
    @(negedge clk);
    chk("flush_drain", 32'(sb.size()), 32'd0);
    step();
  endtask

  task automatic test_rst_mid();
    exp_t e;
    e.r = 3'd0; e.a = 16'h0080; e.ld = 1'b1; e.last = 1'b0;
    sb.push_back(e);
    start = 1; is_lm = 1; reg_list = 8'hF0; base_addr = 16'h0080;
    step();
    start = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({busy, stall_fetch, xfer_valid, xfer_reg, xfer_addr,
           xfer_ld, xfer_st, xfer_last} !== '0) begin
        bad++;
        $display("FAIL rst_mid_outputs busy=%b stall=%b valid=%b",
                 busy, stall_fetch, xfer_valid);
      end
      step();
    end
    chk("rst_mid_drain", 32'(sb.size()), 32'd0);
    run_seq("after_rst", 1'b0, 8'b0100_0010, 16'h1234);
  endtask

  initial begin
    test_reset();
    test_lm_basic();
    test_sm_wrap();
    test_zero_list();
    test_hold();
    test_flush();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
